serial_operand_shifter: RTL and testbench

- Upstream feeder for the serial_adder stage.
- Accepts a parallel operand pair plus a carry-in through a valid/ready handshake.
- Emits one carry-clear cycle, then shifts both operands out LSB-first, one bit per clock.
- Drives the adder's a, b, cin and reset (add_clr) pins directly; bit_valid/last_bit frame the word for the downstream sum collector.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_bit_counter.sv | 41 ++++
 rtl/serial_operand_shifter.sv | 105 ++++++++++
 tb/tb_serial_operand_shifter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and sizing helpers for the serial adder datapath.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit index counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// rtl/serial_bit_counter.sv - bit index counter with load-to-zero, enable and terminal flag at WIDTH-1.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q, count_d;

  // Holds at the terminal value rather than wrapping; only clr restarts it.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/serial_operand_shifter.sv
// rtl/serial_operand_shifter.sv - parallel operand pair to LSB-first serial stream for the serial adder.
// Optional SERIAL_OPLOAD_PIPE_EN: accept the next pair during the last bit, removing the IDLE gap.
module serial_operand_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             cin_word,
  output logic             a,
  output logic             b,
  output logic             cin,
  output logic             add_clr,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             cin_q, cin_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]    cnt;
  logic             shifting;
  logic             load;

  serial_bit_counter #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

  assign shifting = (state_q == SHIFT);

`ifdef SERIAL_OPLOAD_PIPE_EN
  assign in_ready = (state_q == IDLE) || (shifting && cnt_tc);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign load = in_valid && in_ready;

  // A load overrides shifting; in the pipelined build it lands on the last bit's edge.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    cin_d   = cin_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (load) begin
      a_sr_d  = a_word;
      b_sr_d  = b_word;
      cin_d   = cin_word;
      cnt_clr = 1'b1;
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        CLEAR: state_d = SHIFT;
        SHIFT: begin
          a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      cin_q   <= cin_d;
    end
  end

  assign a         = shifting && a_sr_q[0];
  assign b         = shifting && b_sr_q[0];
  assign cin       = shifting && cin_q && (cnt == '0);
  assign add_clr   = (state_q == CLEAR);
  assign bit_valid = shifting;
  assign last_bit  = shifting && cnt_tc;

endmodule

// File: tb/tb_serial_operand_shifter.sv
// tb/tb_serial_operand_shifter.sv - table-driven scoreboard bench with a serial adder model on the outputs.
module tb_serial_operand_shifter;

  localparam int W = 8;
`ifdef SERIAL_OPLOAD_PIPE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         cin_word = 1'b0;
  logic         a, b, cin, add_clr, bit_valid, last_bit;

  always #5 clk = ~clk;

  serial_operand_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .cin_word  (cin_word),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .add_clr   (add_clr),
    .bit_valid (bit_valid),
    .last_bit  (last_bit)
  );

  int   n_total = 0;
  int   n_pass = 0;
  vec_t sb[$];
  int   clr_log[$];
  int   last_log[$];
  int   cyc = 0;
  int   idx = 0;
  int   bits_seen = 0;
  int   words_done = 0;
  logic carry_m = 1'b0;
  logic [W-1:0] a_acc = '0, b_acc = '0, s_acc = '0, c_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (reset && in_ready) assert (!$isunknown(in_valid)) else $error("in_valid unknown while in_ready");
  end

  // Output monitor: a serial adder model fed only by the DUT pins.
  always @(negedge clk) begin
    logic [1:0] t;
    vec_t       e;
    cyc++;
    if (!reset) begin
      idx     = 0;
      carry_m = 1'b0;
    end else begin
      if (add_clr) begin
        carry_m = 1'b0;
        idx     = 0;
        clr_log.push_back(cyc);
        chk("clr_quiet", 32'({bit_valid, a, b, cin}), 32'd0);
      end
      if (bit_valid) begin
        t       = 2'(a) + 2'(b) + 2'(cin) + 2'(carry_m);
        carry_m = t[1];
        if (idx < W) begin
          a_acc[idx] = a;
          b_acc[idx] = b;
          s_acc[idx] = t[0];
          c_acc[idx] = cin;
        end
        chk("last_bit", 32'(last_bit), 32'(idx == W - 1));
        bits_seen++;
        if (last_bit) begin
          last_log.push_back(cyc);
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("a_bits", 32'(a_acc), 32'(e.a));
            chk("b_bits", 32'(b_acc), 32'(e.b));
            chk("cin_bits", 32'(c_acc), 32'(e.cin));
            chk("sum", 32'(s_acc), 32'(e.sum));
            chk("cout", 32'(carry_m), 32'(e.cout));
            words_done++;
          end
        end
        idx++;
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_word   = v.a;
    b_word   = v.b;
    cin_word = v.cin;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a"}, 32'(a), 32'd0);
    chk({tag, "_b"}, 32'(b), 32'd0);
    chk({tag, "_cin"}, 32'(cin), 32'd0);
    chk({tag, "_add_clr"}, 32'(add_clr), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_last_bit"}, 32'(last_bit), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t ff;
    int   base_c, base_l, saved, n;

    tbl[0] = '{8'h0B, 8'h06, 1'b1, 8'h12, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    tbl[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    ff     = tbl[1];

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_outputs_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single word, then a new pair offered mid-word that must be ignored.
    send(tbl[0]);
    a_word   = 8'hC3;
    b_word   = 8'h3C;
    cin_word = 1'b1;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_drain();
    saved = clr_log.size();
    repeat (5) @(negedge clk);
    chk("bp_no_accept", 32'(clr_log.size() - saved), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 1; i < 7; i++) send(tbl[i]);
    wait_drain();

    base_c = clr_log.size();
    base_l = last_log.size();
    repeat (3) send(ff);
    wait_drain();
    chk("b2b_words", 32'(last_log.size() - base_l), 32'd3);
    if (clr_log.size() >= base_c + 3 && last_log.size() >= base_l + 3) begin
      for (int j = 1; j < 3; j++) chk("b2b_gap", 32'(clr_log[base_c + j] - last_log[base_l + j - 1]), 32'(GAP));
    end

    // Reset while bit 3 is on the wire.
    send(tbl[5]);
    n = 0;
    while (idx != 3 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("reach_bit3", 32'(idx), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saved = bits_seen;
    repeat (6) @(negedge clk);
    chk("no_bits_after_reset", 32'(bits_seen - saved), 32'd0);
    send(tbl[4]);
    wait_drain();

    chk("words_done", 32'(words_done), 32'd11);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
